// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: reads the 64-word instruction memory at the PC's
// address, registers the word and hands it to the control unit over a
// valid/ready handshake. A one-cycle inc pulse returns to the PC on acceptance.
// Optional feature macro: IFU_PARITY_EN (per-word even parity with a sticky error).
//
// Handshake: instr_out is valid while instr_valid=1 and is held stable until the
// cycle where instr_valid && instr_ready, which is the single transfer cycle;
// inc is asserted combinationally in exactly that cycle.
module instruction_fetch_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  complete,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_par_inv,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    output logic                  inc,
    output logic                  halted,
    output logic                  parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    halt_pend_q, halt_pend_d;
    logic                    parity_err_q, parity_err_d;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic                    collide;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_par_bad;

    // Write-first read: a same-cycle write to the fetched address bypasses the array.
    assign collide = load_en && (load_addr == addr_q);
    assign rd_data = collide ? load_data : mem[addr_q];

    // Instruction memory write port, active in every state; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

`ifdef IFU_PARITY_EN
    logic par_mem [0:DEPTH-1];
    logic rd_par;

    // Parity array written alongside the data; load_par_inv plants a bad bit.
    always_ff @(posedge clk) begin
        if (load_en) begin
            par_mem[load_addr] <= (^load_data) ^ load_par_inv;
        end
    end

    // Stored parity follows the same write-first bypass as the data word.
    always_comb begin
        rd_par     = collide ? ((^load_data) ^ load_par_inv) : par_mem[addr_q];
        rd_par_bad = (^rd_data) ^ rd_par;
    end
`else
    logic unused_par_inv;
    assign unused_par_inv = load_par_inv;
    assign rd_par_bad     = 1'b0;
`endif

    // State and datapath registers; synchronous reset abandons any fetch in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            instr_q      <= '0;
            halt_pend_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            halt_pend_q  <= halt_pend_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        halt_pend_d  = halt_pend_q;
        parity_err_d = parity_err_q;
        instr_valid  = 1'b0;
        inc          = 1'b0;
        halted       = 1'b0;
        case (state_q)
            IDLE: begin
                if (complete) begin
                    state_d = HALT;
                end else if (en) begin
                    addr_d  = instruction_address;
                    state_d = READ;
                end
            end
            READ: begin
                // A complete seen here must still let this instruction through.
                halt_pend_d = complete;
                if (rd_par_bad) begin
                    parity_err_d = 1'b1;
                    state_d      = HALT;
                end else begin
                    instr_d = rd_data;
                    state_d = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    inc     = 1'b1;
                    state_d = (complete || halt_pend_q) ? HALT : IDLE;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_out  = instr_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed testbench for instruction_fetch_stage: fetch, backpressure,
// write-first collision, reset in VALID, parity fault (IFU_PARITY_EN) and halt.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        complete;
    logic [5:0]  instruction_address;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        load_par_inv;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        inc;
    logic        halted;
    logic        parity_err;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    instruction_fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .complete            (complete),
        .instruction_address (instruction_address),
        .load_en             (load_en),
        .load_addr           (load_addr),
        .load_data           (load_data),
        .load_par_inv        (load_par_inv),
        .instr_ready         (instr_ready),
        .instr_out           (instr_out),
        .instr_valid         (instr_valid),
        .inc                 (inc),
        .halted              (halted),
        .parity_err          (parity_err)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d, input logic pinv);
        load_en      = 1'b1;
        load_addr    = a;
        load_data    = d;
        load_par_inv = pinv;
        tick();
        load_en      = 1'b0;
        load_par_inv = 1'b0;
    endtask

    // Start a fetch from IDLE and wait (bounded) for instr_valid.
    task automatic fetch(input logic [5:0] a, input logic rdy, output int cycles);
        instruction_address = a;
        en                  = 1'b1;
        instr_ready         = rdy;
        cycles              = 0;
        while (!instr_valid && cycles < 8) begin
            tick();
            cycles++;
        end
        if (!instr_valid) begin
            check("fetch_timeout", {31'd0, instr_valid}, 32'd1);
        end
    endtask

    initial begin
        logic seen_valid;
        logic seen_inc;
        rst = 1'b0; en = 1'b0; complete = 1'b0; instruction_address = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0; load_par_inv = 1'b0;
        instr_ready = 1'b0;

        // Reset state
        apply_reset();
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_inc", {31'd0, inc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);

        load(6'd0, 32'hA5A5_A5A5, 1'b0);
        load(6'd1, 32'h0000_1234, 1'b0);
        load(6'd5, 32'h0000_0000, 1'b0);

        // 1. Back-to-back fetches with ready held high
        fetch(6'd0, 1'b1, lat);
        check("t1_latency", lat, 32'd2);
        check("t1_instr", instr_out, 32'hA5A5_A5A5);
        check("t1_inc", {31'd0, inc}, 32'd1);
        instruction_address = 6'd1;
        tick();
        check("t1_inc_one_cycle", {31'd0, inc}, 32'd0);
        check("t1_valid_drop", {31'd0, instr_valid}, 32'd0);
        fetch(6'd1, 1'b1, lat);
        check("t1b_latency", lat, 32'd2);
        check("t1b_instr", instr_out, 32'h0000_1234);
        check("t1b_inc", {31'd0, inc}, 32'd1);
        en = 1'b0;
        tick();

        // 2. Backpressure for 5 cycles, with a write to the held address
        fetch(6'd1, 1'b0, lat);
        check("t2_latency", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
            check("t2_hold_instr", instr_out, 32'h0000_1234);
            check("t2_hold_inc", {31'd0, inc}, 32'd0);
            if (i == 1) begin
                load_en   = 1'b1;
                load_addr = 6'd1;
                load_data = 32'hFFFF_FFFF;
            end else begin
                load_en = 1'b0;
            end
            tick();
        end
        load_en = 1'b0;
        check("t2_after_write_instr", instr_out, 32'h0000_1234);
        instr_ready = 1'b1;
        en          = 1'b0;
        #1;
        check("t2_accept_inc", {31'd0, inc}, 32'd1);
        tick();
        check("t2_post_inc", {31'd0, inc}, 32'd0);
        check("t2_post_valid", {31'd0, instr_valid}, 32'd0);

        // 4. Write-first collision in READ
        instruction_address = 6'd5;
        en          = 1'b1;
        instr_ready = 1'b0;
        tick();
        check("t4_read_valid", {31'd0, instr_valid}, 32'd0);
        load_en   = 1'b1;
        load_addr = 6'd5;
        load_data = 32'hDEAD_BEEF;
        en        = 1'b0;
        tick();
        load_en = 1'b0;
        check("t4_valid", {31'd0, instr_valid}, 32'd1);
        check("t4_instr", instr_out, 32'hDEAD_BEEF);
        instr_ready = 1'b1;
        #1;
        check("t4_inc", {31'd0, inc}, 32'd1);
        tick();

        // 5. Reset while in VALID, then refetch
        fetch(6'd0, 1'b0, lat);
        check("t5_valid_before", {31'd0, instr_valid}, 32'd1);
        en  = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("t5_rst_instr", instr_out, 32'h0);
        check("t5_rst_inc", {31'd0, inc}, 32'd0);
        check("t5_rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        fetch(6'd0, 1'b1, lat);
        check("t5_refetch", instr_out, 32'hA5A5_A5A5);
        en = 1'b0;
        tick();

        // 6. Word loaded with inverted parity
        load(6'd2, 32'h0F0F_0F0F, 1'b1);
`ifdef IFU_PARITY_EN
        instruction_address = 6'd2;
        en          = 1'b1;
        instr_ready = 1'b1;
        seen_valid  = 1'b0;
        seen_inc    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_valid = seen_valid | instr_valid;
            seen_inc   = seen_inc | inc;
        end
        check("t6_no_valid", {31'd0, seen_valid}, 32'd0);
        check("t6_no_inc", {31'd0, seen_inc}, 32'd0);
        check("t6_parity_err", {31'd0, parity_err}, 32'd1);
        check("t6_halted", {31'd0, halted}, 32'd1);
        en = 1'b0;
`else
        seen_valid = 1'b0;
        seen_inc   = 1'b0;
        fetch(6'd2, 1'b1, lat);
        check("t6_latency", lat, 32'd2);
        check("t6_instr", instr_out, 32'h0F0F_0F0F);
        check("t6_inc", {31'd0, inc}, 32'd1);
        check("t6_parity_err", {31'd0, parity_err}, 32'd0);
        en = 1'b0;
        tick();
`endif
        apply_reset();
        check("t6_rst_parity_err", {31'd0, parity_err}, 32'd0);

        // 3. complete pulsed during READ
        instruction_address = 6'd0;
        en          = 1'b1;
        instr_ready = 1'b1;
        tick();
        complete = 1'b1;
        tick();
        complete = 1'b0;
        check("t3_valid", {31'd0, instr_valid}, 32'd1);
        check("t3_instr", instr_out, 32'hA5A5_A5A5);
        check("t3_inc", {31'd0, inc}, 32'd1);
        tick();
        check("t3_halted", {31'd0, halted}, 32'd1);
        check("t3_halt_valid", {31'd0, instr_valid}, 32'd0);
        check("t3_halt_inc", {31'd0, inc}, 32'd0);
        load(6'd3, 32'h0000_0033, 1'b0);
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_valid = seen_valid | instr_valid;
        end
        check("t3_no_valid_after_halt", {31'd0, seen_valid}, 32'd0);
        check("t3_still_halted", {31'd0, halted}, 32'd1);
        en = 1'b0;
        apply_reset();
        check("t3_rst_unhalts", {31'd0, halted}, 32'd0);
        fetch(6'd3, 1'b1, lat);
        check("t3_halt_write", instr_out, 32'h0000_0033);
        en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
